// File: rtl/pipe_stage_skid_reg_if.sv
// Stage-boundary bundle: upstream beat (in_*) and downstream beat (out_*) of one pipeline stage.
// Handshake: a beat moves when valid & ready are both high at a rising clk edge; ready never depends combinationally on valid.
interface pipe_stage_skid_reg_if #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_ctrl, in_data, in_addr, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, out_addr
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, in_addr, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, out_addr
  );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with a two-entry skid buffer, flush/squash, bubble-zeroed control
// and saturating stall/kill counters.
module pipe_stage_skid_reg #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  pipe_stage_skid_reg_if.slave bus,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     kill_cnt,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [ADDR_W-1:0] main_addr_q, skid_addr_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  kill_cnt_q, kill_cnt_d;

  logic              main_valid, skid_valid, accept, drain, stall;
  logic [1:0]        kill_inc;
  logic [CNT_W:0]    stall_sum, kill_sum;

  always_comb begin
    main_valid  = (state_q != ST_EMPTY);
    skid_valid  = (state_q == ST_SKID);
    accept      = bus.in_valid & in_ready_q;
    drain       = main_valid & bus.out_ready;
    stall       = main_valid & ~bus.out_ready;
    // Beats lost to a flush: undelivered main, held skid, and the same-cycle input beat.
    kill_inc    = 2'(main_valid & ~drain) + 2'(skid_valid) + 2'(accept);
    stall_sum   = {1'b0, stall_cnt_q} + (CNT_W+1)'(stall);
    kill_sum    = {1'b0, kill_cnt_q} + (CNT_W+1)'(kill_inc);
    stall_cnt_d = stall_sum[CNT_W] ? {CNT_W{1'b1}} : stall_sum[CNT_W-1:0];
    kill_cnt_d  = kill_cnt_q;
    if (flush) begin
      kill_cnt_d = kill_sum[CNT_W] ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      main_addr_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_addr_q <= '0;
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
      in_ready_q  <= 1'b1;
      if (flush) begin
        state_q     <= ST_EMPTY;
        main_ctrl_q <= '0;
        skid_ctrl_q <= '0;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              main_ctrl_q <= bus.in_ctrl;
              main_data_q <= bus.in_data;
              main_addr_q <= bus.in_addr;
              state_q     <= ST_FULL;
            end
          end
          ST_FULL: begin
            if (accept && drain) begin
              main_ctrl_q <= bus.in_ctrl;
              main_data_q <= bus.in_data;
              main_addr_q <= bus.in_addr;
            end else if (accept) begin
              skid_ctrl_q <= bus.in_ctrl;
              skid_data_q <= bus.in_data;
              skid_addr_q <= bus.in_addr;
              state_q     <= ST_SKID;
              in_ready_q  <= 1'b0;
            end else if (drain) begin
              state_q <= ST_EMPTY;
            end
          end
          ST_SKID: begin
            if (drain) begin
              main_ctrl_q <= skid_ctrl_q;
              main_data_q <= skid_data_q;
              main_addr_q <= skid_addr_q;
              state_q     <= ST_FULL;
            end else begin
              in_ready_q <= 1'b0;
            end
          end
          default: state_q <= ST_EMPTY;
        endcase
      end
    end
  end

  // Bubble: an invalid stage never presents asserted control bits.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_ctrl  = main_ctrl_q & {CTRL_W{main_valid}};
  assign bus.out_data  = main_data_q;
  assign bus.out_addr  = main_addr_q;
  assign stall_cnt     = stall_cnt_q;
  assign kill_cnt      = kill_cnt_q;
  assign state_o       = state_q;

endmodule
